// File: rtl/bus_xfer_sched.sv
// Single-transfer bus scheduler: waits for a free destination, pops the brq head, drives a fixed grant tenure.
// Optional WAIT-cycle stall counter is built only when BXS_STALL_CNT_EN is defined.
module bus_xfer_sched #(
   parameter int XFER_BEATS = 4,
   parameter int WAIT_LIMIT = 32
) (
   input  logic        clk_i,
   input  logic        clr_n_i,
   input  logic        req_ready_i,
   input  logic [3:0]  send_out_i,
   input  logic [3:0]  dest_out_i,
   input  logic [15:0] free_i,
   output logic        pull_o,
   output logic [15:0] grant_send_o,
   output logic [15:0] grant_dest_o,
   output logic        bus_busy_o,
   output logic        beat_last_o,
   output logic        wait_timeout_o,
   output logic [15:0] stall_cycles_o
);

   localparam logic [3:0]  BEAT_LAST = 4'(XFER_BEATS - 1);
   localparam logic [15:0] WAIT_MAX  = 16'(WAIT_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_XFER = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cur_send_q, cur_send_d;
   logic [3:0]  cur_dest_q, cur_dest_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic [3:0]  beat_q, beat_d;
   logic        timeout_q, timeout_d;
   logic        pull_q, pull_d;
   logic        busy_q, busy_d;
   logic        beat_last_q, beat_last_d;
   logic [15:0] grant_send_q, grant_send_d;
   logic [15:0] grant_dest_q, grant_dest_d;
   logic        xfer_d;

   always_comb begin
      state_d    = state_q;
      cur_send_d = cur_send_q;
      cur_dest_d = cur_dest_q;
      case (state_q)
         S_IDLE: begin
            if (req_ready_i) begin
               cur_send_d = send_out_i;
               cur_dest_d = dest_out_i;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            // A dropped head wins over a free destination: nothing is popped.
            if (!req_ready_i) begin
               state_d = S_IDLE;
            end else if (free_i[cur_dest_q]) begin
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (beat_q == BEAT_LAST) begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Counters and outputs are derived from the next state so every output is a flop.
   always_comb begin
      wait_cnt_d  = 16'd0;
      beat_d      = 4'd0;
      timeout_d   = timeout_q;
      pull_d      = 1'b0;
      busy_d      = 1'b0;
      beat_last_d = 1'b0;
      if (state_d == S_WAIT) begin
         if (state_q != S_WAIT) begin
            wait_cnt_d = 16'd1;
         end else if (wait_cnt_q == WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q;
         end else begin
            wait_cnt_d = wait_cnt_q + 16'd1;
         end
         if (wait_cnt_d == WAIT_MAX) begin
            timeout_d = 1'b1;
         end
      end
      if (state_d == S_XFER) begin
         beat_d      = (state_q == S_XFER) ? beat_q + 4'd1 : 4'd0;
         pull_d      = (state_q != S_XFER);
         beat_last_d = (beat_d == BEAT_LAST);
      end
      busy_d = (state_d != S_IDLE);
   end

   assign xfer_d = (state_d == S_XFER);

   for (genvar gi = 0; gi < 16; gi++) begin : g_grant
      assign grant_send_d[gi] = xfer_d && (cur_send_d == 4'(gi));
      assign grant_dest_d[gi] = xfer_d && (cur_dest_d == 4'(gi));
   end

   always_ff @(posedge clk_i or negedge clr_n_i) begin
      if (!clr_n_i) begin
         state_q      <= S_IDLE;
         cur_send_q   <= 4'd0;
         cur_dest_q   <= 4'd0;
         wait_cnt_q   <= 16'd0;
         beat_q       <= 4'd0;
         timeout_q    <= 1'b0;
         pull_q       <= 1'b0;
         busy_q       <= 1'b0;
         beat_last_q  <= 1'b0;
         grant_send_q <= 16'd0;
         grant_dest_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         cur_send_q   <= cur_send_d;
         cur_dest_q   <= cur_dest_d;
         wait_cnt_q   <= wait_cnt_d;
         beat_q       <= beat_d;
         timeout_q    <= timeout_d;
         pull_q       <= pull_d;
         busy_q       <= busy_d;
         beat_last_q  <= beat_last_d;
         grant_send_q <= grant_send_d;
         grant_dest_q <= grant_dest_d;
      end
   end

`ifdef BXS_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_d == S_WAIT) && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge clr_n_i) begin
      if (!clr_n_i) begin
         stall_q <= 16'd0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles_o = stall_q;
`else
   assign stall_cycles_o = 16'h0000;
`endif

   assign pull_o         = pull_q;
   assign grant_send_o   = grant_send_q;
   assign grant_dest_o   = grant_dest_q;
   assign bus_busy_o     = busy_q;
   assign beat_last_o    = beat_last_q;
   assign wait_timeout_o = timeout_q;

endmodule
